// File: rtl/cvp14_pkg.sv
// cvp14_pkg: shared definitions for the cvp14 16-bit multicycle core.
//   - DATA_W      : datapath width
//   - OP_*        : 4-bit opcode values held in IR[15:12]
//   - state_e     : control FSM states
//   - sext*       : sign-extension helpers for the immediate fields
package cvp14_pkg;

    localparam int DATA_W = 16;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_NOR  = 4'h3;
    localparam logic [3:0] OP_SLL  = 4'h4;
    localparam logic [3:0] OP_SRL  = 4'h5;
    localparam logic [3:0] OP_LLB  = 4'h6;
    localparam logic [3:0] OP_LHB  = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_BEQZ = 4'hA;
    localparam logic [3:0] OP_BNEZ = 4'hB;
    localparam logic [3:0] OP_JAL  = 4'hC;
    localparam logic [3:0] OP_JR   = 4'hD;
    localparam logic [3:0] OP_NOP  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        LDWB,
        HALT
    } state_e;

    function automatic logic [DATA_W-1:0] sext6(input logic [5:0] v);
        return {{(DATA_W-6){v[5]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] sext8(input logic [7:0] v);
        return {{(DATA_W-8){v[7]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] sext9(input logic [8:0] v);
        return {{(DATA_W-9){v[8]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] sext12(input logic [11:0] v);
        return {{(DATA_W-12){v[11]}}, v};
    endfunction

endpackage

// File: rtl/cvp14_alu.sv
// cvp14_alu: combinational ALU of the cvp14 core.
//   a_i, b_i  : operands (b_i[3:0] is the shift amount for SLL/SRL)
//   op_i      : opcode; any non-ALU opcode produces a_i + b_i
//   result_o  : 16-bit wrapped result
//   ovf_o     : signed overflow, meaningful for ADD and SUB only
module cvp14_alu
    import cvp14_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [3:0]        op_i,
    output logic [DATA_W-1:0] result_o,
    output logic              ovf_o
);

    always_comb begin
        result_o = a_i + b_i;
        ovf_o    = 1'b0;
        case (op_i)
            OP_ADD: begin
                result_o = a_i + b_i;
                // Same-signed operands producing a differently signed sum.
                ovf_o = (a_i[DATA_W-1] == b_i[DATA_W-1]) &&
                        (result_o[DATA_W-1] != a_i[DATA_W-1]);
            end
            OP_SUB: begin
                result_o = a_i - b_i;
                // Differently signed operands where the result takes b's sign.
                ovf_o = (a_i[DATA_W-1] != b_i[DATA_W-1]) &&
                        (result_o[DATA_W-1] != a_i[DATA_W-1]);
            end
            OP_AND:  result_o = a_i & b_i;
            OP_NOR:  result_o = ~(a_i | b_i);
            OP_SLL:  result_o = a_i << b_i[3:0];
            OP_SRL:  result_o = a_i >> b_i[3:0];
            default: result_o = a_i + b_i;
        endcase
    end

endmodule

// File: rtl/cvp14_cpu.sv
// cvp14_cpu: 16-bit multicycle scalar core with one shared memory port.
//   Clk1     : clock, all state changes on the rising edge
//   Reset    : synchronous active-high reset
//   DataIn   : RAM read data, valid the cycle after RD
//   Addr     : RAM word address (PC, or MAR during MEM)
//   RD / WR  : RAM read / write strobes, never both high
//   V        : overflow flag written by ADD/SUB
//   dataOut  : store data, nonzero only while a store is on the bus
module cvp14_cpu
    import cvp14_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic              Clk1,
    input  logic              Reset,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] Addr,
    output logic              RD,
    output logic              WR,
    output logic              V,
    output logic [DATA_W-1:0] dataOut
);

    state_e            state_q;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] mar_q;
    logic [DATA_W-1:0] rf_q [8];
    logic              v_q;

    logic [3:0]        op;
    logic [2:0]        rd_idx, rs_idx, rt_idx;
    logic [DATA_W-1:0] rd_val, rs_val, rt_val;
    logic [DATA_W-1:0] alu_b, alu_res, wb_d;
    logic [3:0]        alu_op;
    logic              alu_ovf;
    logic              writes_rd;

    assign op     = ir_q[15:12];
    assign rd_idx = ir_q[11:9];
    assign rs_idx = ir_q[8:6];
    assign rt_idx = ir_q[5:3];

    // R0 is hard-wired to zero on every read port.
    assign rd_val = (rd_idx == 3'd0) ? '0 : rf_q[rd_idx];
    assign rs_val = (rs_idx == 3'd0) ? '0 : rf_q[rs_idx];
    assign rt_val = (rt_idx == 3'd0) ? '0 : rf_q[rt_idx];

    // The ALU also forms LD/ST effective addresses (rs + sext(imm6)).
    always_comb begin
        alu_op = op;
        alu_b  = rt_val;
        if (op == OP_LD || op == OP_ST) begin
            alu_op = OP_ADD;
            alu_b  = sext6(ir_q[5:0]);
        end else if (op == OP_SLL || op == OP_SRL) begin
            alu_b = {{(DATA_W-4){1'b0}}, ir_q[3:0]};
        end
    end

    cvp14_alu u_alu (
        .a_i      (rs_val),
        .b_i      (alu_b),
        .op_i     (alu_op),
        .result_o (alu_res),
        .ovf_o    (alu_ovf)
    );

    always_comb begin
        case (op)
            OP_LLB:  wb_d = sext8(ir_q[7:0]);
            OP_LHB:  wb_d = {ir_q[7:0], rd_val[7:0]};
            default: wb_d = alu_res;
        endcase
    end

    // Opcodes 0..7 all retire in EXEC by writing rd.
    assign writes_rd = (op[3] == 1'b0);

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            mar_q   <= '0;
            v_q     <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    state_q <= DECODE;
                end
                DECODE: begin
                    ir_q    <= DataIn;
                    pc_q    <= pc_q + 16'd1;
                    state_q <= EXEC;
                end
                EXEC: begin
                    state_q <= FETCH;
                    if (writes_rd) begin
                        if (rd_idx != 3'd0) begin
                            rf_q[rd_idx] <= wb_d;
                        end
                        if (op == OP_ADD || op == OP_SUB) begin
                            v_q <= alu_ovf;
                        end
                    end else begin
                        case (op)
                            OP_LD, OP_ST: begin
                                mar_q   <= alu_res;
                                state_q <= MEM;
                            end
                            // pc_q already points past this instruction.
                            OP_BEQZ: if (rd_val == '0) pc_q <= pc_q + sext9(ir_q[8:0]);
                            OP_BNEZ: if (rd_val != '0) pc_q <= pc_q + sext9(ir_q[8:0]);
                            OP_JAL: begin
                                rf_q[7] <= pc_q;
                                pc_q    <= pc_q + sext12(ir_q[11:0]);
                            end
                            OP_JR:   pc_q    <= rs_val;
                            OP_HLT:  state_q <= HALT;
                            default: state_q <= FETCH;
                        endcase
                    end
                end
                MEM: begin
                    state_q <= (op == OP_LD) ? LDWB : FETCH;
                end
                LDWB: begin
                    if (rd_idx != 3'd0) begin
                        rf_q[rd_idx] <= DataIn;
                    end
                    state_q <= FETCH;
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    // Strobes are qualified with Reset so an asserted reset kills any bus
    // cycle in progress; in particular a store caught in MEM never writes.
    assign RD      = !Reset && ((state_q == FETCH) || (state_q == MEM && op == OP_LD));
    assign WR      = !Reset && (state_q == MEM) && (op == OP_ST);
    assign Addr    = (state_q == MEM) ? mar_q : pc_q;
    assign dataOut = ((state_q == MEM) && (op == OP_ST)) ? rd_val : '0;
    assign V       = v_q;

endmodule

// File: tb/tb_cvp14_cpu.sv
module tb_cvp14_cpu;
    import cvp14_pkg::*;

    logic        Clk1 = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] DataIn;
    logic [15:0] Addr;
    logic        RD, WR, V;
    logic [15:0] dataOut;

    cvp14_cpu #(.RESET_PC(16'h0000)) dut (
        .Clk1    (Clk1),
        .Reset   (Reset),
        .DataIn  (DataIn),
        .Addr    (Addr),
        .RD      (RD),
        .WR      (WR),
        .V       (V),
        .dataOut (dataOut)
    );

    always #5 Clk1 = ~Clk1;

    // RAM model: img is the program/data image loaded by the stimulus,
    // wmem/wv hold words written by the core since the last clear.
    logic [15:0] img  [0:65535];
    logic [15:0] wmem [0:65535];
    logic        wv   [0:65535];
    logic [15:0] rdata = 16'h0000;
    logic        clr = 1'b0;
    assign DataIn = rdata;

    always @(posedge Clk1) begin
        if (clr) begin
            for (int i = 0; i < 65536; i++) wv[i] <= 1'b0;
        end else if (WR) begin
            wmem[Addr] <= dataOut;
            wv[Addr]   <= 1'b1;
        end
        if (RD) rdata <= wv[Addr] ? wmem[Addr] : img[Addr];
    end

    function automatic logic [15:0] ram_val(input logic [15:0] a);
        return wv[a] ? wmem[a] : img[a];
    endfunction

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard of expected stores {addr, data}, consumed by the monitor.
    logic [31:0] exp_q [$];
    logic [31:0] e;
    int cyc = -1;
    int last_rd = -1;

    always @(negedge Clk1) begin
        if (Reset) begin
            cyc = -1;
        end else begin
            cyc++;
            if (RD) last_rd = cyc;
            chk("rd_wr_exclusive", {31'd0, RD & WR}, 32'd0);
            if (WR) begin
                chk("wr_pending", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("wr_addr", {16'd0, Addr}, {16'd0, e[31:16]});
                    chk("wr_data", {16'd0, dataOut}, {16'd0, e[15:0]});
                end
            end
        end
    end

    // Instruction encoders
    function automatic logic [15:0] r3(input logic [3:0] op, input int rd, input int rs, input int rt);
        return {op, rd[2:0], rs[2:0], rt[2:0], 3'b000};
    endfunction
    function automatic logic [15:0] i8(input logic [3:0] op, input int rd, input int imm);
        return {op, rd[2:0], 1'b0, imm[7:0]};
    endfunction
    function automatic logic [15:0] mi(input logic [3:0] op, input int rd, input int rs, input int imm);
        return {op, rd[2:0], rs[2:0], imm[5:0]};
    endfunction
    function automatic logic [15:0] sh(input logic [3:0] op, input int rd, input int rs, input int amt);
        return {op, rd[2:0], rs[2:0], 2'b00, amt[3:0]};
    endfunction
    function automatic logic [15:0] br(input logic [3:0] op, input int rd, input int off);
        return {op, rd[2:0], off[8:0]};
    endfunction
    function automatic logic [15:0] jal(input int off);
        return {OP_JAL, off[11:0]};
    endfunction

    localparam logic [15:0] HLT = 16'hF000;
    localparam logic [15:0] NOP = 16'hE000;

    task automatic clear_img();
        for (int i = 0; i < 65536; i++) img[i] = HLT;
        exp_q.delete();
    endtask

    task automatic put(input int a, input logic [15:0] w);
        img[a[15:0]] = w;
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] d);
        exp_q.push_back({a, d});
    endtask

    // Hold reset for two edges, check the reset-state outputs, release it
    // and check the first fetch in the following cycle.
    task automatic do_reset();
        @(posedge Clk1); #1;
        Reset = 1'b1;
        clr   = 1'b1;
        @(posedge Clk1); #1;
        clr = 1'b0;
        @(posedge Clk1);
        @(negedge Clk1);
        chk("rst_RD", {31'd0, RD}, 32'd0);
        chk("rst_WR", {31'd0, WR}, 32'd0);
        chk("rst_Addr", {16'd0, Addr}, 32'd0);
        chk("rst_dataOut", {16'd0, dataOut}, 32'd0);
        chk("rst_V", {31'd0, V}, 32'd0);
        @(posedge Clk1); #1;
        Reset = 1'b0;
        @(negedge Clk1);
        chk("first_fetch_RD", {31'd0, RD}, 32'd1);
        chk("first_fetch_Addr", {16'd0, Addr}, 32'd0);
    endtask

    // Wait (bounded) until the bus stays idle, then check the cycle of the
    // HLT fetch and that every expected store was seen.
    task automatic run_to_halt(input string tag, input int exp_hlt, input logic exp_v);
        int idle = 0;
        int n = 0;
        while (idle < 4 && n < 3000) begin
            @(negedge Clk1);
            n++;
            idle = (!RD && !WR) ? idle + 1 : 0;
        end
        chk({tag, "_halted"}, {31'd0, idle >= 4}, 32'd1);
        chk({tag, "_hlt_cycle"}, last_rd, exp_hlt);
        chk({tag, "_stores_left"}, exp_q.size(), 32'd0);
        chk({tag, "_V"}, {31'd0, V}, {31'd0, exp_v});
        exp_q.delete();
    endtask

    initial begin
        // Basic ADD
        clear_img();
        put(0, i8(OP_LLB, 1, 8'h05));
        put(1, i8(OP_LLB, 2, 8'h03));
        put(2, r3(OP_ADD, 3, 1, 2));
        put(3, i8(OP_LLB, 4, 8'h40));
        put(4, mi(OP_ST, 3, 4, 0));
        put(5, HLT);
        push(16'h0040, 16'h0008);
        do_reset();
        run_to_halt("p1", 16, 1'b0);

        // Overflow set by ADD, held across AND/LLB/ST
        clear_img();
        put(0, i8(OP_LLB, 1, 8'h7F));
        put(1, i8(OP_LHB, 1, 8'h7F));
        put(2, r3(OP_ADD, 2, 1, 1));
        put(3, r3(OP_AND, 5, 2, 1));
        put(4, i8(OP_LLB, 4, 8'h40));
        put(5, mi(OP_ST, 2, 4, 0));
        put(6, mi(OP_ST, 5, 4, 1));
        put(7, HLT);
        push(16'h0040, 16'hFEFE);
        push(16'h0041, 16'h7E7E);
        do_reset();
        run_to_halt("p2a", 23, 1'b1);

        // SUB to zero clears overflow
        clear_img();
        put(0, i8(OP_LLB, 1, 8'h7F));
        put(1, i8(OP_LHB, 1, 8'h7F));
        put(2, r3(OP_ADD, 2, 1, 1));
        put(3, r3(OP_SUB, 3, 2, 2));
        put(4, i8(OP_LLB, 4, 8'h40));
        put(5, mi(OP_ST, 3, 4, 0));
        put(6, HLT);
        push(16'h0040, 16'h0000);
        do_reset();
        run_to_halt("p2b", 19, 1'b0);

        // Store / load, including a negative offset
        clear_img();
        put(0, i8(OP_LLB, 4, 8'h20));
        put(1, i8(OP_LLB, 5, 8'hAB));
        put(2, mi(OP_ST, 5, 4, 1));
        put(3, mi(OP_LD, 6, 4, 1));
        put(4, i8(OP_LLB, 7, 8'h30));
        put(5, mi(OP_ST, 6, 7, 0));
        put(6, mi(OP_LD, 2, 4, -1));
        put(7, mi(OP_ST, 2, 7, 1));
        put(8, HLT);
        put(16'h001F, 16'h1234);
        push(16'h0021, 16'hFFAB);
        push(16'h0030, 16'hFFAB);
        push(16'h0031, 16'h1234);
        do_reset();
        run_to_halt("p3", 31, 1'b0);

        // Branches, JAL, JR
        clear_img();
        put(16'h00, i8(OP_LLB, 4, 8'h40));
        put(16'h01, br(OP_BEQZ, 0, 14));
        put(16'h10, br(OP_BEQZ, 0, 2));
        put(16'h11, i8(OP_LLB, 1, 8'hEE));
        put(16'h12, mi(OP_ST, 1, 4, 0));
        put(16'h13, br(OP_BNEZ, 0, 2));
        put(16'h14, i8(OP_LLB, 2, 8'h11));
        put(16'h15, jal(5));
        put(16'h16, mi(OP_ST, 2, 4, 1));
        put(16'h17, mi(OP_ST, 7, 4, 2));
        put(16'h18, HLT);
        put(16'h1B, mi(OP_ST, 7, 4, 3));
        put(16'h1C, mi(OP_JR, 0, 7, 0));
        push(16'h0043, 16'h0016);
        push(16'h0041, 16'h0011);
        push(16'h0042, 16'h0016);
        do_reset();
        run_to_halt("p4", 33, 1'b0);

        // PC wrap FFFF->0000 and wrapping branch target
        clear_img();
        put(16'h0000, i8(OP_LLB, 1, 8'hFE));
        put(16'h0001, mi(OP_JR, 0, 1, 0));
        put(16'h0002, HLT);
        put(16'h0003, i8(OP_LLB, 4, 8'h40));
        put(16'h0004, mi(OP_ST, 2, 4, 0));
        put(16'h0005, HLT);
        put(16'hFFFE, i8(OP_LLB, 2, 8'h55));
        put(16'hFFFF, br(OP_BEQZ, 0, 3));
        push(16'h0040, 16'h0055);
        do_reset();
        run_to_halt("p5", 19, 1'b0);

        // Reset while a store sits in MEM
        clear_img();
        put(0, i8(OP_LLB, 4, 8'h40));
        put(1, i8(OP_LLB, 5, 8'h77));
        put(2, mi(OP_ST, 5, 4, 0));
        put(3, HLT);
        put(16'h0040, 16'hDEAD);
        do_reset();
        repeat (9) @(posedge Clk1);
        #1;
        Reset = 1'b1;
        @(negedge Clk1);
        chk("abort_WR", {31'd0, WR}, 32'd0);
        @(posedge Clk1); #1;
        Reset = 1'b0;
        put(1, NOP);
        @(negedge Clk1);
        chk("abort_no_write", {16'd0, ram_val(16'h0040)}, 32'h0000DEAD);
        chk("abort_fetch_RD", {31'd0, RD}, 32'd1);
        chk("abort_fetch_Addr", {16'd0, Addr}, 32'd0);
        push(16'h0040, 16'h0000);
        run_to_halt("p6", 10, 1'b0);

        // R0 stays zero, shifts, NOR, SUB overflow
        clear_img();
        put(0, i8(OP_LLB, 1, 8'h05));
        put(1, r3(OP_ADD, 0, 1, 1));
        put(2, i8(OP_LLB, 4, 8'h40));
        put(3, mi(OP_ST, 0, 4, 0));
        put(4, i8(OP_LLB, 2, 8'h00));
        put(5, i8(OP_LHB, 2, 8'h80));
        put(6, sh(OP_SRL, 3, 2, 15));
        put(7, mi(OP_ST, 3, 4, 1));
        put(8, sh(OP_SLL, 5, 1, 4));
        put(9, r3(OP_NOR, 6, 1, 0));
        put(10, mi(OP_ST, 5, 4, 2));
        put(11, mi(OP_ST, 6, 4, 3));
        put(12, r3(OP_SUB, 7, 2, 1));
        put(13, mi(OP_ST, 7, 4, 4));
        put(14, HLT);
        push(16'h0040, 16'h0000);
        push(16'h0041, 16'h0001);
        push(16'h0042, 16'h0050);
        push(16'h0043, 16'hFFFA);
        push(16'h0044, 16'h7FFB);
        do_reset();
        run_to_halt("p7", 47, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
